// File: rtl/loop_addr_gen_if.sv
// rtl/loop_addr_gen_if.sv - loop controller, sample address and bank-clear signal bundle
interface loop_addr_gen_if;
    logic        sample_tick;
    logic [15:0] recording;
    logic [15:0] playing;
    logic        set_max;
    logic        reset_max;
    logic        delete;
    logic [3:0]  delete_bank;
    logic        clr_ack;
    logic [21:0] current_address;
    logic [21:0] current_max;
    logic        delete_clear;
    logic        clr_req;
    logic [3:0]  clr_bank;
    logic [21:0] clr_addr;
    logic        busy;

    // master: the address generator; slave: loop controller plus memory arbiter
    modport master (
        input  sample_tick, recording, playing, set_max, reset_max,
               delete, delete_bank, clr_ack,
        output current_address, current_max, delete_clear,
               clr_req, clr_bank, clr_addr, busy
    );

    modport slave (
        output sample_tick, recording, playing, set_max, reset_max,
               delete, delete_bank, clr_ack,
        input  current_address, current_max, delete_clear,
               clr_req, clr_bank, clr_addr, busy
    );
endinterface

// File: rtl/loop_addr_gen.sv
// rtl/loop_addr_gen.sv - shared loop sample address counter with bank-clear write sequencer
module loop_addr_gen #(
    parameter logic [21:0] ADDR_LAST = 22'h3FFFFF
) (
    input  logic           clk100,
    input  logic           rst,
    loop_addr_gen_if.master bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    logic [21:0] r_addr;
    logic [21:0] r_max;
    logic        w_loop_set;
    logic        w_set_ok;
    logic        w_advance;
    logic        w_wrap;

    assign w_loop_set = (r_max != 22'd0);
    assign w_set_ok   = bus.set_max && !w_loop_set && (r_addr != 22'd0);
    // Before the loop length is known only recording moves the counter
    assign w_advance  = w_loop_set ? (|(bus.recording | bus.playing)) : (|bus.recording);
    assign w_wrap     = w_loop_set ? (r_addr == r_max - 22'd1) : (r_addr == ADDR_LAST);

    always_ff @(posedge clk100) begin
        if (rst) begin
            r_addr <= '0;
            r_max  <= '0;
        end else if (bus.reset_max) begin
            r_addr <= '0;
            r_max  <= '0;
        end else if (w_set_ok) begin
            r_max  <= r_addr;
            r_addr <= '0;
        end else if (bus.sample_tick && w_advance) begin
            r_addr <= w_wrap ? 22'd0 : r_addr + 22'd1;
        end
    end

    clr_state_t  r_state;
    clr_state_t  w_state_next;
    logic [21:0] r_clr_addr;
    logic [21:0] w_clr_addr_next;
    logic [3:0]  r_clr_bank;
    logic [3:0]  w_clr_bank_next;
    logic [21:0] r_limit;
    logic [21:0] w_limit_next;
    logic        r_clr_req;
    logic        r_busy;
    logic        r_delete_clear;

    always_comb begin
        w_state_next    = r_state;
        w_clr_addr_next = r_clr_addr;
        w_clr_bank_next = r_clr_bank;
        w_limit_next    = r_limit;
        case (r_state)
            IDLE: begin
                if (bus.delete) begin
                    w_state_next    = CLEAR;
                    w_clr_bank_next = bus.delete_bank;
                    w_clr_addr_next = '0;
                    w_limit_next    = w_loop_set ? (r_max - 22'd1) : ADDR_LAST;
                end
            end
            CLEAR: begin
                if (bus.clr_ack) begin
                    if (r_clr_addr == r_limit) begin
                        w_state_next = DONE;
                    end else begin
                        w_clr_addr_next = r_clr_addr + 22'd1;
                    end
                end
            end
            DONE: begin
                if (!bus.delete) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Status outputs are flopped from the next state so they align with r_state
    always_ff @(posedge clk100) begin
        if (rst) begin
            r_state        <= IDLE;
            r_clr_addr     <= '0;
            r_clr_bank     <= '0;
            r_limit        <= '0;
            r_clr_req      <= 1'b0;
            r_busy         <= 1'b0;
            r_delete_clear <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_clr_addr     <= w_clr_addr_next;
            r_clr_bank     <= w_clr_bank_next;
            r_limit        <= w_limit_next;
            r_clr_req      <= (w_state_next == CLEAR);
            r_busy         <= (w_state_next != IDLE);
            r_delete_clear <= (w_state_next == DONE);
        end
    end

    assign bus.current_address = r_addr;
    assign bus.current_max     = r_max;
    assign bus.clr_req         = r_clr_req;
    assign bus.clr_addr        = r_clr_addr;
    assign bus.clr_bank        = r_clr_bank;
    assign bus.busy            = r_busy;
    assign bus.delete_clear    = r_delete_clear;
endmodule

// File: tb/tb_loop_addr_gen.sv
// tb/tb_loop_addr_gen.sv - scoreboard bench for loop_addr_gen
`timescale 1ns/1ps
module tb_loop_addr_gen;
    logic clk100 = 1'b0;
    logic rst;
    always #5 clk100 = ~clk100;

    loop_addr_gen_if m_if();
    loop_addr_gen_if s_if();

    loop_addr_gen dut (
        .clk100(clk100),
        .rst   (rst),
        .bus   (m_if.master)
    );

    loop_addr_gen #(.ADDR_LAST(22'd15)) dut_s (
        .clk100(clk100),
        .rst   (rst),
        .bus   (s_if.master)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [21:0] q_addr[$];
    logic [25:0] q_clr[$];

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    task automatic idle_inputs();
        m_if.sample_tick = 0; m_if.recording = '0; m_if.playing = '0;
        m_if.set_max = 0; m_if.reset_max = 0; m_if.delete = 0;
        m_if.delete_bank = '0; m_if.clr_ack = 0;
        s_if.sample_tick = 0; s_if.recording = '0; s_if.playing = '0;
        s_if.set_max = 0; s_if.reset_max = 0; s_if.delete = 0;
        s_if.delete_bank = '0; s_if.clr_ack = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        n_total++;
        if (m_if.current_address !== 22'd0) $display("FAIL reset_addr: got %0h want 0", m_if.current_address);
        else n_pass++;
        n_total++;
        if (m_if.current_max !== 22'd0) $display("FAIL reset_max: got %0h want 0", m_if.current_max);
        else n_pass++;
        n_total++;
        if ({m_if.clr_req, m_if.busy, m_if.delete_clear} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {m_if.clr_req, m_if.busy, m_if.delete_clear});
        else n_pass++;
        n_total++;
        if ({m_if.clr_bank, m_if.clr_addr} !== 26'd0)
            $display("FAIL reset_clr: got bank %0h addr %0h want 0/0", m_if.clr_bank, m_if.clr_addr);
        else n_pass++;
    endtask

    task automatic test_record_set_max();
        logic [21:0] exp_addr;
        logic [21:0] got;
        exp_addr = 0;
        m_if.recording = 16'h0001;
        for (int i = 0; i < 100; i++) begin
            m_if.sample_tick = 1;
            exp_addr = exp_addr + 1;
            q_addr.push_back(exp_addr);
            step();
            got = q_addr.pop_front();
            n_total++;
            if (m_if.current_address !== got) $display("FAIL record_addr: got %0d want %0d", m_if.current_address, got);
            else n_pass++;
        end
        m_if.sample_tick = 0;
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        n_total++;
        if (m_if.current_max !== 22'd100 || m_if.current_address !== 22'd0)
            $display("FAIL set_max: got max %0d addr %0d want 100/0", m_if.current_max, m_if.current_address);
        else n_pass++;
        m_if.recording = '0;
        m_if.playing = 16'h0001;
        exp_addr = 0;
        for (int i = 0; i < 100; i++) begin
            m_if.sample_tick = 1;
            exp_addr = (exp_addr == 22'd99) ? 22'd0 : exp_addr + 1;
            q_addr.push_back(exp_addr);
            step();
            got = q_addr.pop_front();
            n_total++;
            if (m_if.current_address !== got) $display("FAIL play_addr: got %0d want %0d", m_if.current_address, got);
            else n_pass++;
        end
        m_if.sample_tick = 0;
        m_if.playing = '0;
    endtask

    task automatic test_coincident();
        m_if.playing = 16'h0004;
        m_if.sample_tick = 1;
        repeat (3) step();
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        n_total++;
        if (m_if.current_max !== 22'd100 || m_if.current_address !== 22'd4)
            $display("FAIL set_max_ignored: got max %0d addr %0d want 100/4", m_if.current_max, m_if.current_address);
        else n_pass++;
        m_if.playing = '0;
        step();
        n_total++;
        if (m_if.current_address !== 22'd4) $display("FAIL idle_hold: got %0d want 4", m_if.current_address);
        else n_pass++;
        m_if.sample_tick = 0;
        m_if.reset_max = 1;
        step();
        m_if.reset_max = 0;
        n_total++;
        if (m_if.current_max !== 22'd0 || m_if.current_address !== 22'd0)
            $display("FAIL reset_max: got max %0d addr %0d want 0/0", m_if.current_max, m_if.current_address);
        else n_pass++;
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        n_total++;
        if (m_if.current_max !== 22'd0) $display("FAIL set_max_at_zero: got %0d want 0", m_if.current_max);
        else n_pass++;
        m_if.playing = 16'h8000;
        m_if.sample_tick = 1;
        repeat (2) step();
        n_total++;
        if (m_if.current_address !== 22'd0) $display("FAIL play_before_loop: got %0d want 0", m_if.current_address);
        else n_pass++;
        m_if.playing = '0;
        m_if.recording = 16'h0100;
        repeat (5) step();
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        m_if.sample_tick = 0;
        n_total++;
        if (m_if.current_max !== 22'd5 || m_if.current_address !== 22'd0)
            $display("FAIL set_with_tick: got max %0d addr %0d want 5/0", m_if.current_max, m_if.current_address);
        else n_pass++;
        m_if.reset_max = 1;
        m_if.set_max = 1;
        step();
        m_if.reset_max = 0;
        m_if.set_max = 0;
        m_if.recording = '0;
        n_total++;
        if (m_if.current_max !== 22'd0) $display("FAIL reset_over_set: got %0d want 0", m_if.current_max);
        else n_pass++;
    endtask

    task automatic test_clear_defined();
        logic [25:0] e;
        int n_req;
        int n_steps;
        bit done;
        m_if.recording = 16'h0001;
        m_if.sample_tick = 1;
        repeat (8) step();
        m_if.sample_tick = 0;
        m_if.recording = '0;
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        n_total++;
        if (m_if.current_max !== 22'd8) $display("FAIL max8: got %0d want 8", m_if.current_max);
        else n_pass++;
        for (int a = 0; a < 8; a++) q_clr.push_back({4'd3, 22'(a)});
        m_if.delete = 1;
        m_if.delete_bank = 4'd3;
        m_if.clr_ack = 1;
        m_if.playing = 16'h0002;
        m_if.sample_tick = 1;
        n_req = 0;
        n_steps = 0;
        done = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (m_if.delete_clear) begin
                done = 1;
                break;
            end
            if (m_if.clr_req) begin
                n_req++;
                if (q_clr.size() == 0) begin
                    n_total++;
                    $display("FAIL clr_extra: got bank %0d addr %0d want none", m_if.clr_bank, m_if.clr_addr);
                end else begin
                    e = q_clr.pop_front();
                    n_total++;
                    if ({m_if.clr_bank, m_if.clr_addr} !== e)
                        $display("FAIL clr_write: got %0d/%0d want %0d/%0d", m_if.clr_bank, m_if.clr_addr, e[25:22], e[21:0]);
                    else n_pass++;
                end
            end
            step();
            n_steps++;
        end
        m_if.sample_tick = 0;
        m_if.playing = '0;
        n_total++;
        if (!done || n_req != 8 || q_clr.size() != 0)
            $display("FAIL clr_count: got done %0d req %0d left %0d want 1/8/0", done, n_req, q_clr.size());
        else n_pass++;
        n_total++;
        if (m_if.current_address !== 22'(n_steps % 8))
            $display("FAIL addr_during_clear: got %0d want %0d", m_if.current_address, n_steps % 8);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if ({m_if.delete_clear, m_if.busy, m_if.clr_req} !== 3'b110)
            $display("FAIL done_hold: got %b want 110", {m_if.delete_clear, m_if.busy, m_if.clr_req});
        else n_pass++;
        m_if.delete = 0;
        m_if.clr_ack = 0;
        step();
        n_total++;
        if ({m_if.delete_clear, m_if.busy, m_if.clr_req} !== 3'b000)
            $display("FAIL done_exit: got %b want 000", {m_if.delete_clear, m_if.busy, m_if.clr_req});
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [25:0] e;
        logic [21:0] held;
        int n_ack;
        int bad_hold;
        bit done;
        bit chk_hold;
        m_if.reset_max = 1;
        step();
        m_if.reset_max = 0;
        m_if.recording = 16'h0010;
        m_if.sample_tick = 1;
        repeat (4) step();
        m_if.sample_tick = 0;
        m_if.recording = '0;
        m_if.set_max = 1;
        step();
        m_if.set_max = 0;
        for (int a = 0; a < 4; a++) q_clr.push_back({4'd9, 22'(a)});
        m_if.delete = 1;
        m_if.delete_bank = 4'd9;
        m_if.clr_ack = 0;
        n_ack = 0;
        bad_hold = 0;
        done = 0;
        chk_hold = 0;
        held = '0;
        step();
        for (int cyc = 0; cyc < 60; cyc++) begin
            m_if.reset_max = 0;
            if (chk_hold && m_if.clr_addr !== held) bad_hold++;
            chk_hold = 0;
            if (m_if.delete_clear) begin
                done = 1;
                break;
            end
            m_if.clr_ack = cyc[0];
            if (m_if.clr_req && m_if.clr_ack) begin
                n_ack++;
                if (n_ack == 1) m_if.reset_max = 1;
                if (n_ack == 2) m_if.delete = 0;
                if (q_clr.size() == 0) begin
                    n_total++;
                    $display("FAIL bp_extra: got addr %0d want none", m_if.clr_addr);
                end else begin
                    e = q_clr.pop_front();
                    n_total++;
                    if ({m_if.clr_bank, m_if.clr_addr} !== e)
                        $display("FAIL bp_write: got %0d/%0d want %0d/%0d", m_if.clr_bank, m_if.clr_addr, e[25:22], e[21:0]);
                    else n_pass++;
                end
            end else if (m_if.clr_req) begin
                held = m_if.clr_addr;
                chk_hold = 1;
            end
            step();
        end
        m_if.clr_ack = 0;
        n_total++;
        if (!done || n_ack != 4 || q_clr.size() != 0 || bad_hold != 0)
            $display("FAIL bp_count: got done %0d acks %0d left %0d holdbad %0d want 1/4/0/0", done, n_ack, q_clr.size(), bad_hold);
        else n_pass++;
        n_total++;
        if (m_if.current_max !== 22'd0) $display("FAIL bp_max_cleared: got %0d want 0", m_if.current_max);
        else n_pass++;
        step();
        n_total++;
        if ({m_if.delete_clear, m_if.busy} !== 2'b00)
            $display("FAIL bp_done_exit: got %b want 00", {m_if.delete_clear, m_if.busy});
        else n_pass++;
    endtask

    task automatic test_clear_small();
        logic [21:0] exp_addr;
        logic [21:0] got;
        logic [25:0] e;
        int n_ack;
        bit done;
        exp_addr = 0;
        s_if.recording = 16'h0001;
        for (int i = 0; i < 18; i++) begin
            s_if.sample_tick = 1;
            exp_addr = (exp_addr == 22'd15) ? 22'd0 : exp_addr + 1;
            q_addr.push_back(exp_addr);
            step();
            got = q_addr.pop_front();
            n_total++;
            if (s_if.current_address !== got) $display("FAIL wrap_addr: got %0d want %0d", s_if.current_address, got);
            else n_pass++;
        end
        s_if.sample_tick = 0;
        s_if.recording = '0;
        for (int a = 0; a < 16; a++) q_clr.push_back({4'd5, 22'(a)});
        s_if.delete = 1;
        s_if.delete_bank = 4'd5;
        s_if.clr_ack = 1;
        n_ack = 0;
        done = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (s_if.delete_clear) begin
                done = 1;
                break;
            end
            if (s_if.clr_req) begin
                n_ack++;
                if (q_clr.size() != 0) begin
                    e = q_clr.pop_front();
                    n_total++;
                    if ({s_if.clr_bank, s_if.clr_addr} !== e)
                        $display("FAIL small_write: got %0d/%0d want %0d/%0d", s_if.clr_bank, s_if.clr_addr, e[25:22], e[21:0]);
                    else n_pass++;
                end
            end
            step();
        end
        n_total++;
        if (!done || n_ack != 16 || q_clr.size() != 0)
            $display("FAIL small_count: got done %0d writes %0d left %0d want 1/16/0", done, n_ack, q_clr.size());
        else n_pass++;
        s_if.delete = 0;
        s_if.clr_ack = 0;
        step();
    endtask

    task automatic test_reset_mid_clear();
        bit hit;
        m_if.delete = 1;
        m_if.delete_bank = 4'd2;
        m_if.clr_ack = 1;
        hit = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (m_if.clr_req && m_if.clr_addr == 22'd5) begin
                hit = 1;
                break;
            end
            step();
        end
        n_total++;
        if (!hit) $display("FAIL mid_reach: got clr_addr %0d want 5", m_if.clr_addr);
        else n_pass++;
        rst = 1;
        m_if.delete = 0;
        step();
        rst = 0;
        n_total++;
        if ({m_if.clr_req, m_if.busy, m_if.delete_clear, m_if.clr_bank, m_if.clr_addr,
             m_if.current_address, m_if.current_max} !== 73'd0)
            $display("FAIL mid_reset: got req %b busy %b dc %b bank %0d addr %0d cur %0d max %0d want all 0",
                     m_if.clr_req, m_if.busy, m_if.delete_clear, m_if.clr_bank, m_if.clr_addr,
                     m_if.current_address, m_if.current_max);
        else n_pass++;
        step();
        n_total++;
        if ({m_if.clr_req, m_if.busy} !== 2'b00)
            $display("FAIL after_reset: got req %b busy %b want 0/0", m_if.clr_req, m_if.busy);
        else n_pass++;
        m_if.clr_ack = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_record_set_max();
        test_coincident();
        test_clear_defined();
        test_backpressure();
        test_clear_small();
        test_reset_mid_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/loop_addr_gen.md
LOOP_ADDR_GEN -- requirements
Module: loop_addr_gen

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk100 is the only clock and rst is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_LAST, default 22'h3FFFFF, meaning the last sample address of each bank buffer.
REQ-003 The block SHALL have these ports:
- clk100  in  1  system clock
- rst  in  1  synchronous active-high reset
- sample_tick  in  1  one-cycle audio sample strobe
- recording  in  16  per-bank record flags from the loop controller
- playing  in  16  per-bank play flags from the loop controller
- set_max  in  1  latch the loop length (one-cycle pulse)
- reset_max  in  1  clear the loop length (level or pulse)
- delete  in  1  bank-clear request; held until delete_clear is seen
- delete_bank  in  4  bank to clear
- clr_ack  in  1  memory arbiter accepted the current clear write
- current_address  out  22  sample address shared by all banks
- current_max  out  22  loop length in samples; 0 means no loop is defined yet
- delete_clear  out  1  clear complete
- clr_req  out  1  clear write request
- clr_bank  out  4  bank being cleared
- clr_addr  out  22  address being cleared
- busy  out  1  high whenever the clear FSM is not in IDLE

Function
REQ-004 Address counter before the loop is defined (current_max==0): on sample_tick with recording!=0, current_address SHALL increment; after ADDR_LAST it SHALL wrap to 0.
REQ-005 Address counter before the loop is defined: with recording==0, current_address SHALL hold.
REQ-006 Address counter after the loop is defined (current_max!=0): on sample_tick with (recording|playing)!=0, current_address SHALL increment.
REQ-007 Address counter after the loop is defined: when current_address==current_max-1, the next tick SHALL load 0. When (recording|playing)==0, current_address SHALL hold.
REQ-008 set_max: if current_max==0 and current_address!=0, then current_max<=current_address and current_address<=0 on the next edge.
REQ-009 set_max SHALL be ignored if current_max!=0 or if current_address==0.
REQ-010 reset_max SHALL set current_max<=0 and current_address<=0.
REQ-011 Priority in one cycle SHALL be rst > reset_max > set_max > sample_tick; a tick that coincides with an accepted set_max is dropped.
REQ-012 The clear FSM SHALL have the states IDLE, CLEAR and DONE.
REQ-013 IDLE: when delete==1, the FSM SHALL latch clr_bank<=delete_bank, set clr_addr<=0, latch the clear limit, and go to CLEAR.
REQ-014 The clear limit SHALL be current_max-1 if current_max!=0, else ADDR_LAST. It is latched on entry to CLEAR, and later changes to current_max SHALL NOT alter it.
REQ-015 CLEAR: clr_req SHALL be 1. On clr_ack, if clr_addr==limit the FSM SHALL go to DONE; otherwise clr_addr increments. Without clr_ack, clr_addr, clr_bank and clr_req SHALL hold.
REQ-016 DONE: delete_clear SHALL be 1 and clr_req 0. The FSM SHALL stay in DONE until delete==0, then return to IDLE, so delete_clear is at least one cycle wide.
REQ-017 A delete deasserted mid-CLEAR SHALL NOT abort the clear; the FSM finishes and passes through DONE, which exits on the next cycle.
REQ-018 The address counter SHALL keep running during CLEAR; the clear path is independent of current_address.
REQ-019 Output latency: all outputs SHALL be registered, with state and counters updating on the clk100 edge after the qualifying input.

Reset
REQ-020 On rst: current_address=0, current_max=0, clr_addr=0, clr_bank=0, clr_req=0, delete_clear=0, busy=0, FSM=IDLE.
REQ-021 rst asserted mid-CLEAR SHALL abort the clear with no further clr_req.

Verification
REQ-022 Record and set loop length: recording=16'h0001, 100 ticks, then set_max -> current_max=100, current_address=0; after 100 more ticks with playing=1 -> current_address back at 0; tick 99 shows 99.
REQ-023 Coincident controls: set_max and sample_tick in the same cycle -> address=0, no increment. reset_max and set_max in the same cycle -> current_max=0.
REQ-024 Clear with a defined loop: current_max=8, delete=1, delete_bank=3, clr_ack tied 1 -> clr_req for exactly 8 cycles with clr_addr 0..7 and clr_bank=3. Then delete_clear=1, held until delete drops; FSM back in IDLE.
REQ-025 Arbiter backpressure: clr_ack toggling 1/0 with current_max=4 -> clr_addr advances only on ack cycles, 4 acknowledged writes total, no address skipped or repeated.
REQ-026 Clear before loop length is set: current_max=0, ADDR_LAST overridden to 15 -> 16 writes, addresses 0..15.
REQ-027 Reset mid-clear: rst at clr_addr=5 -> next cycle clr_req=0, busy=0, delete_clear=0, all outputs at reset values.
